// File: rtl/montgomery_exp_ctrl.sv
// Montgomery modular-exponentiation sequencer.
// Computes x^e mod m by sequencing one external Montgomery multiplier
// (MontMul(a,b) = a*b*R^-1 mod m, R = 2^WIDTH) over a start/done handshake.
// Supports square-and-multiply and a constant-time Montgomery ladder, with a
// runtime exponent length (MSB = bit e_len-1).
module montgomery_exp_ctrl #(
    parameter int WIDTH     = 512,
    parameter int EXP_WIDTH = 512,
    parameter int LEN_W     = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 ladder,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     modulus,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [LEN_W-1:0]     e_len,
    input  logic [WIDTH-1:0]     rmodm,
    input  logic [WIDTH-1:0]     r2modm,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic [15:0]          mul_count,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    output logic [WIDTH-1:0]     mul_modulus,
    input  logic                 mul_done,
    input  logic [WIDTH-1:0]     mul_result
);

    // Longest exponent the register can hold; larger e_len values clamp here.
    localparam logic [LEN_W-1:0] EXP_LEN = LEN_W'(EXP_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOMONT,
        S_OP1,
        S_OP2,
        S_FROMMONT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // issued_q: the current op state has already pulsed mul_start and is
    // now waiting for mul_done.
    logic                 issued_q,    issued_d;
    logic                 ladder_q,    ladder_d;
    logic [WIDTH-1:0]     a_q,         a_d;        // accumulator A (Montgomery domain)
    logic [WIDTH-1:0]     x_q,         x_d;        // raw base, then X in Montgomery domain
    logic [WIDTH-1:0]     r2_q,        r2_d;
    logic [WIDTH-1:0]     mod_q,       mod_d;
    logic [EXP_WIDTH-1:0] e_q,         e_d;
    logic [LEN_W-1:0]     cnt_q,       cnt_d;      // exponent bits still to process
    logic [15:0]          mul_count_q, mul_count_d;
    logic                 mul_start_q, mul_start_d;
    logic [WIDTH-1:0]     mul_a_q,     mul_a_d;
    logic [WIDTH-1:0]     mul_b_q,     mul_b_d;
    logic [WIDTH-1:0]     result_q,    result_d;

    // Operand routing for the current op state.
    logic [WIDTH-1:0]     op_a, op_b;
    logic                 dst_x;                   // 1: write X, 0: write A
    logic                 cur_bit;
    logic [LEN_W-1:0]     bit_idx;
    logic                 last_bit;

    // Select the current exponent bit and the MontMul operands/destination.
    always_comb begin
        bit_idx  = cnt_q - LEN_W'(1);
        cur_bit  = |(e_q & (EXP_WIDTH'(1) << bit_idx));
        last_bit = (cnt_q == LEN_W'(1));
        op_a     = a_q;
        op_b     = a_q;
        dst_x    = 1'b0;
        case (state_q)
            S_TOMONT: begin
                op_a  = x_q;
                op_b  = r2_q;
                dst_x = 1'b1;
            end
            S_OP1: begin
                // Square-and-multiply squares A; ladder multiplies A*X and
                // writes A when the bit is set, X otherwise.
                if (ladder_q) begin
                    op_b  = x_q;
                    dst_x = !cur_bit;
                end
            end
            S_OP2: begin
                if (ladder_q) begin
                    if (cur_bit) begin
                        op_a  = x_q;
                        op_b  = x_q;
                        dst_x = 1'b1;
                    end
                end else begin
                    op_b = x_q;
                end
            end
            S_FROMMONT: begin
                op_b = WIDTH'(1);
            end
            default: ;
        endcase
    end

    // Sequencer: next state, register writes and multiplier handshake.
    always_comb begin
        state_d     = state_q;
        issued_d    = issued_q;
        ladder_d    = ladder_q;
        a_d         = a_q;
        x_d         = x_q;
        r2_d        = r2_q;
        mod_d       = mod_q;
        e_d         = e_q;
        cnt_d       = cnt_q;
        mul_count_d = mul_count_q;
        mul_start_d = 1'b0;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        result_d    = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ladder_d    = ladder;
                    x_d         = x;
                    a_d         = rmodm;
                    r2_d        = r2modm;
                    mod_d       = modulus;
                    e_d         = exponent;
                    cnt_d       = (e_len > EXP_LEN) ? EXP_LEN : e_len;
                    mul_count_d = 16'd0;
                    issued_d    = 1'b0;
                    state_d     = S_TOMONT;
                end
            end
            S_TOMONT, S_OP1, S_OP2, S_FROMMONT: begin
                if (!issued_q) begin
                    // Operands are registered with the start pulse and held
                    // until the multiplier answers.
                    mul_start_d = 1'b1;
                    mul_a_d     = op_a;
                    mul_b_d     = op_b;
                    issued_d    = 1'b1;
                    mul_count_d = (mul_count_q == 16'hFFFF) ? mul_count_q
                                                            : mul_count_q + 16'd1;
                end else if (mul_done) begin
                    issued_d = 1'b0;
                    if (dst_x) x_d = mul_result;
                    else       a_d = mul_result;
                    case (state_q)
                        S_TOMONT: begin
                            state_d = (cnt_q == '0) ? S_FROMMONT : S_OP1;
                        end
                        S_OP1: begin
                            // Square-and-multiply skips the second op on a 0 bit.
                            if (ladder_q || cur_bit) begin
                                state_d = S_OP2;
                            end else begin
                                cnt_d   = cnt_q - LEN_W'(1);
                                state_d = last_bit ? S_FROMMONT : S_OP1;
                            end
                        end
                        S_OP2: begin
                            cnt_d   = cnt_q - LEN_W'(1);
                            state_d = last_bit ? S_FROMMONT : S_OP1;
                        end
                        default: begin
                            result_d = mul_result;
                            state_d  = S_DONE;
                        end
                    endcase
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            issued_q    <= 1'b0;
            ladder_q    <= 1'b0;
            a_q         <= '0;
            x_q         <= '0;
            r2_q        <= '0;
            mod_q       <= '0;
            e_q         <= '0;
            cnt_q       <= '0;
            mul_count_q <= 16'd0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            issued_q    <= issued_d;
            ladder_q    <= ladder_d;
            a_q         <= a_d;
            x_q         <= x_d;
            r2_q        <= r2_d;
            mod_q       <= mod_d;
            e_q         <= e_d;
            cnt_q       <= cnt_d;
            mul_count_q <= mul_count_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            result_q    <= result_d;
        end
    end

    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done        = (state_q == S_DONE);
    assign result      = result_q;
    assign mul_count   = mul_count_q;
    assign mul_start   = mul_start_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign mul_modulus = mod_q;

endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
// Bench for montgomery_exp_ctrl: an 8-bit instance driven from a vector table
// plus hand-written corner sequences, and a 512-bit instance checked against
// a plain modular-exponentiation model. Both multipliers are behavioural
// MontMul models with random 1-20 cycle latency.
module tb_montgomery_exp_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 8-bit instance
    logic        st8, ld8, busy8, done8, ms8, md8, md8a, md8f;
    logic [7:0]  x8, m8, e8, rm8, r28, res8, ma8, mb8, mm8, mr8;
    logic [3:0]  el8;
    logic [15:0] cnt8;

    // 512-bit instance
    logic         st5, ld5, busy5, done5, ms5, md5;
    logic [511:0] x5, m5, e5, rm5, r25, res5, ma5, mb5, mm5, mr5;
    logic [9:0]   el5;
    logic [15:0]  cnt5;

    montgomery_exp_ctrl #(.WIDTH(8), .EXP_WIDTH(8), .LEN_W(4)) dut8 (
        .clk(clk), .reset(reset), .start(st8), .ladder(ld8), .x(x8), .modulus(m8),
        .exponent(e8), .e_len(el8), .rmodm(rm8), .r2modm(r28), .busy(busy8),
        .done(done8), .result(res8), .mul_count(cnt8), .mul_start(ms8), .mul_a(ma8),
        .mul_b(mb8), .mul_modulus(mm8), .mul_done(md8), .mul_result(mr8));

    montgomery_exp_ctrl #(.WIDTH(512), .EXP_WIDTH(512), .LEN_W(10)) dut5 (
        .clk(clk), .reset(reset), .start(st5), .ladder(ld5), .x(x5), .modulus(m5),
        .exponent(e5), .e_len(el5), .rmodm(rm5), .r2modm(r25), .busy(busy5),
        .done(done5), .result(res5), .mul_count(cnt5), .mul_start(ms5), .mul_a(ma5),
        .mul_b(mb5), .mul_modulus(mm5), .mul_done(md5), .mul_result(mr5));

    int n_chk  = 0;
    int n_pass = 0;
    bit lat_fix = 1'b0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Bit-serial Montgomery reduction of a*b (a, b < m, m odd).
    function automatic logic [511:0] montmul(input logic [511:0] a, input logic [511:0] b,
                                             input logic [511:0] m, input int w);
        logic [1039:0] acc;
        acc = 1040'(a) * 1040'(b);
        for (int i = 0; i < w; i++) begin
            if (acc[0]) acc = acc + 1040'(m);
            acc = acc >> 1;
        end
        if (acc >= 1040'(m)) acc = acc - 1040'(m);
        return acc[511:0];
    endfunction

    // Reference x^e mod m with ordinary modular arithmetic.
    function automatic logic [511:0] modexp(input logic [511:0] b, input logic [511:0] e,
                                            input logic [511:0] m, input int len);
        logic [1023:0] r, mm, bb;
        r  = 1024'(1);
        mm = {512'b0, m};
        bb = {512'b0, b};
        for (int i = len - 1; i >= 0; i--) begin
            r = (r * r) % mm;
            if (e[i]) r = (r * bb) % mm;
        end
        return r[511:0];
    endfunction

    // Multiplier models: answer each mul_start after a 1-20 cycle delay.
    int           pend8 = 0, pend5 = 0;
    logic [511:0] q8, q5;
    logic         md5a;
    always @(negedge clk) begin
        md8a <= 1'b0;
        if (ms8) begin
            q8    <= montmul({504'b0, ma8}, {504'b0, mb8}, {504'b0, mm8}, 8);
            pend8 <= lat_fix ? 3 : int'($urandom_range(1, 20));
        end else if (pend8 > 0) begin
            pend8 <= pend8 - 1;
            if (pend8 == 1) begin
                md8a <= 1'b1;
                mr8  <= q8[7:0];
            end
        end
    end
    always @(negedge clk) begin
        md5a <= 1'b0;
        if (ms5) begin
            q5    <= montmul(ma5, mb5, mm5, 512);
            pend5 <= lat_fix ? 3 : int'($urandom_range(1, 20));
        end else if (pend5 > 0) begin
            pend5 <= pend5 - 1;
            if (pend5 == 1) begin
                md5a <= 1'b1;
                mr5  <= q5;
            end
        end
    end
    assign md8 = md8a | md8f;
    assign md5 = md5a;

    int ndone8 = 0;
    always @(negedge clk) if (done8) ndone8 <= ndone8 + 1;

    typedef struct {
        logic        ld;
        logic [7:0]  x, m, e;
        logic [3:0]  len;
        logic [7:0]  rm, r2, res;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[12];
    int   runs8 = 0;

    // One 8-bit operation; optional second start while busy and optional
    // mul_done poke during the DONE cycle.
    task automatic run8(input string tag, input vec_t v, input int restart_at,
                        input bit poke, output int cyc);
        logic [15:0] c;
        @(negedge clk);
        ld8 = v.ld; x8 = v.x; m8 = v.m; e8 = v.e; el8 = v.len; rm8 = v.rm; r28 = v.r2;
        st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        chk({tag, " busy after start"}, busy8, 1);
        chk({tag, " mul_modulus"}, mm8, v.m);
        // Inputs must have been latched; scramble them.
        ld8 = ~v.ld; x8 = 8'hA5; m8 = 8'h3B; e8 = 8'h00; el8 = 4'd1; rm8 = 8'h11; r28 = 8'h22;
        cyc = 1;
        while (!done8 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            st8 = 1'b0;
            if (cyc == restart_at) begin
                st8 = 1'b1; x8 = 8'd7; e8 = 8'hFF; el8 = 4'd8;
            end
        end
        st8 = 1'b0;
        chk({tag, " done seen"}, done8, 1);
        chk({tag, " result"}, res8, v.res);
        chk({tag, " mul_count"}, cnt8, v.cnt);
        chk({tag, " busy low at done"}, busy8, 0);
        runs8++;
        c = cnt8;
        if (poke) md8f = 1'b1;
        @(negedge clk);
        md8f = 1'b0;
        chk({tag, " done one cycle"}, done8, 0);
        chk({tag, " count held"}, cnt8, c);
        chk({tag, " result held"}, res8, v.res);
    endtask

    task automatic run5(input logic lad, input logic [511:0] expr, input logic [15:0] expc);
        int n;
        @(negedge clk);
        ld5 = lad; st5 = 1'b1;
        @(negedge clk);
        st5 = 1'b0;
        chk("w512 busy", busy5, 1);
        n = 0;
        while (!done5 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("w512 done seen", done5, 1);
        chk(lad ? "w512 ladder result" : "w512 sqmul result", res5, expr);
        chk(lad ? "w512 ladder count" : "w512 sqmul count", cnt5, expc);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc, cyc_a, cyc_b, n, nd;
        logic [1023:0] t;
        logic [511:0]  exp5;
        vec_t v;

        //          ld    x      m       e      len   rm     r2     res     cnt
        tbl[0]  = '{1'b0, 8'd2,  8'd13,  8'h05, 4'd3, 8'd9,  8'd3,  8'd6,   16'd7};
        tbl[1]  = '{1'b1, 8'd2,  8'd13,  8'h05, 4'd3, 8'd9,  8'd3,  8'd6,   16'd8};
        tbl[2]  = '{1'b0, 8'd2,  8'd13,  8'h05, 4'd0, 8'd9,  8'd3,  8'd1,   16'd2};
        tbl[3]  = '{1'b1, 8'd2,  8'd13,  8'h05, 4'd0, 8'd9,  8'd3,  8'd1,   16'd2};
        tbl[4]  = '{1'b0, 8'd2,  8'd13,  8'h0F, 4'd2, 8'd9,  8'd3,  8'd8,   16'd6};
        tbl[5]  = '{1'b1, 8'd2,  8'd13,  8'h0F, 4'd2, 8'd9,  8'd3,  8'd8,   16'd6};
        tbl[6]  = '{1'b0, 8'd7,  8'd13,  8'hFF, 4'd8, 8'd9,  8'd3,  8'd5,   16'd18};
        tbl[7]  = '{1'b1, 8'd2,  8'd13,  8'h03, 4'd15, 8'd9, 8'd3,  8'd8,   16'd18};
        tbl[8]  = '{1'b0, 8'd2,  8'd13,  8'h03, 4'd15, 8'd9, 8'd3,  8'd8,   16'd12};
        tbl[9]  = '{1'b0, 8'd10, 8'd251, 8'h02, 4'd2, 8'd5,  8'd25, 8'd100, 16'd5};
        tbl[10] = '{1'b1, 8'd10, 8'd251, 8'h02, 4'd2, 8'd5,  8'd25, 8'd100, 16'd6};
        tbl[11] = '{1'b0, 8'd2,  8'd255, 8'h07, 4'd3, 8'd1,  8'd1,  8'd128, 16'd8};

        reset = 1'b1; md8f = 1'b0;
        st8 = 1'b0; ld8 = 1'b0; x8 = '0; m8 = '0; e8 = '0; el8 = '0; rm8 = '0; r28 = '0;
        st5 = 1'b0; ld5 = 1'b0; x5 = '0; m5 = '0; e5 = '0; el5 = '0; rm5 = '0; r25 = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy8, 0);
        chk("reset done", done8, 0);
        chk("reset result", res8, 0);
        chk("reset mul_count", cnt8, 0);
        chk("reset mul_start", ms8, 0);
        chk("reset mul_a", ma8, 0);
        chk("reset mul_b", mb8, 0);
        chk("reset mul_modulus", mm8, 0);
        chk("reset w512 result", res5, 0);
        reset = 1'b0;
        @(negedge clk);

        // Table vectors; vector 0 also pokes mul_done during DONE.
        foreach (tbl[i]) run8($sformatf("vec%0d", i), tbl[i], 0, i == 0, cyc);

        // start while busy must be ignored.
        run8("restart-while-busy", tbl[0], 5, 1'b0, cyc);

        // mul_done in IDLE.
        nd = ndone8;
        @(negedge clk); md8f = 1'b1;
        @(negedge clk); md8f = 1'b0;
        chk("idle poke busy", busy8, 0);
        @(negedge clk);
        chk("idle poke done", done8, 0);
        chk("idle poke no done pulse", ndone8, nd);
        chk("idle poke count", cnt8, tbl[0].cnt);

        // Ladder timing is independent of the exponent bits.
        lat_fix = 1'b1;
        repeat (25) @(negedge clk);
        run8("ladder fixed e5", tbl[1], 0, 1'b0, cyc_a);
        v = tbl[1]; v.e = 8'h02; v.res = 8'd4;
        run8("ladder fixed e2", v, 0, 1'b0, cyc_b);
        chk("ladder timing equal", cyc_b, cyc_a);
        lat_fix = 1'b0;

        // Reset mid-ladder aborts; the multiplier's late answer is ignored.
        @(negedge clk);
        ld8 = 1'b1; x8 = 8'd2; m8 = 8'd13; e8 = 8'h05; el8 = 4'd3; rm8 = 8'd9; r28 = 8'd3;
        st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        n = 0;
        while (cnt8 < 16'd3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("mid-ladder reached", busy8, 1);
        nd = ndone8;
        reset = 1'b1;
        #1;
        chk("abort busy", busy8, 0);
        chk("abort mul_count", cnt8, 0);
        chk("abort mul_start", ms8, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        chk("after abort busy", busy8, 0);
        chk("after abort no done", ndone8, nd);
        chk("after abort result", res8, 0);
        run8("post-reset", tbl[0], 0, 1'b0, cyc);
        chk("done pulse total", ndone8, runs8);

        // 512-bit vector.
        for (int k = 0; k < 16; k++) m5[k*32 +: 32] = $urandom;
        m5[511] = 1'b1; m5[0] = 1'b1;
        for (int k = 0; k < 16; k++) x5[k*32 +: 32] = $urandom;
        x5[511] = 1'b0;
        t    = 1024'(1) << 512;
        rm5  = 512'(t % {512'b0, m5});
        t    = {512'b0, rm5} * {512'b0, rm5};
        r25  = 512'(t % {512'b0, m5});
        e5   = 512'h0b7;
        el5  = 10'd8;
        exp5 = modexp(x5, e5, m5, 8);
        run5(1'b0, exp5, 16'd16);
        run5(1'b1, exp5, 16'd18);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
